dfe_apb_slave: RTL and testbench
================================

# dfe_apb_slave

APB responder holding the DFE configuration: CIC decimation factor, block enables and the ten biquad coefficients of the two-section notch filter. It sits between the system APB initiator and the DFE datapath inside the top-level module. It decodes SETUP/ACCESS transfers, flags illegal accesses, and applies new coefficients atomically on a datapath sample boundary so the notch never runs with a half-updated coefficient set.

## Interface
- ABP_ADDR_WIDTH, 4, APB address width (word index).
- ABP_DATA_WIDTH, 32, APB data width.
- DFE_DATA_WIDTH, 16, coefficient width.
- PCLK  in  1  single clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  ABP_ADDR_WIDTH  register index.
- PWDATA  in  ABP_DATA_WIDTH  write data.
- PRDATA  out  ABP_DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error, valid with PREADY.
- sample_tick  in  1  one-cycle pulse at each datapath sample boundary (clkdiv falling-edge equivalent).
- blk_en  out  5  block enables.
- cic_log2_d  out  5  CIC decimation = 2^cic_log2_d.
- b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2  out  DFE_DATA_WIDTH each  active coefficients.
- cfg_update  out  1  one-cycle pulse when the active set changes.

## Operation
- Register map by PADDR:
  - 0x0 CTRL: [4:0] blk_en, [13:9] cic_log2_d, all other bits read 0.
  - 0x1 STATUS (RO): [0] commit_pending, [15:8] saturating error count.
  - 0x2 {b0_1, b1_1}, 0x3 {b2_1, a1_1}, 0x4 {a2_1, b0_2}, 0x5 {b1_2, b2_2}, 0x6 {a1_2, a2_2}. Upper half is [31:16].
  - 0x7 COMMIT (WO): writing bit0=1 sets commit_pending. Reads return 0.
- FSM states and transitions:
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS on PSEL & PENABLE.
  - ACCESS -> SETUP if PSEL & !PENABLE; otherwise ACCESS -> IDLE.
  - PENABLE without a prior SETUP is ignored: no write, PREADY stays 0.
- No wait states. PREADY=1 exactly in the ACCESS cycle.
- A write commits on the ACCESS cycle edge.
- Error (PSLVERR=1 in ACCESS, write discarded, error count +1 saturating at 255) on any of:
  - address 0x8..0xF;
  - write to 0x1;
  - CTRL write with [13:9] > 4.
- Reads of 0x8..0xF also error and return PRDATA=0.
- PRDATA is registered at SETUP and held through ACCESS; it is 0 in all other cycles.
- Commit:
  - On sample_tick with commit_pending=1: active coefficients <= shadow, cfg_update=1 for one cycle, pending cleared.
  - COMMIT write in the same cycle as sample_tick: pending is set, and the commit waits for the next tick.
  - Shadow writes while pending are allowed; the last value written before the tick is applied.
- CTRL is not shadowed: blk_en and cic_log2_d update on the write edge.
- Coefficient reads return shadow values.

## Timing
- Reset values: all outputs 0, including shadow registers, active registers, error count and pending; FSM in IDLE.
- Reset asserted mid-transfer aborts it, with no partial write. The first transfer after release needs a full SETUP.
- Write to visible output:
  - CTRL: 1 PCLK after the ACCESS edge.
  - Coefficients: first sample_tick after COMMIT; active values and cfg_update appear on the edge following that tick.
- Back-to-back transfers (ACCESS followed directly by SETUP) are supported at 2 cycles per transfer.

## Configuration
- DFE_APB_SHADOW_EN defined: shadow/commit behaviour as above.
- DFE_APB_SHADOW_EN undefined:
  - Coefficient writes drive the active registers directly.
  - cfg_update pulses 1 cycle after each accepted coefficient write.
  - 0x7 behaves as a normal write with no error; the write has no effect.
  - STATUS[0] reads 0.

## Test plan
- Reset, then read all 0x0..0x7 -> PRDATA=0, PSLVERR=0, all outputs 0.
- Write 0x0 = {5'd4, 9'h01F} -> blk_en=5'h1F, cic_log2_d=4, read 0x0 returns 0x0000081F.
- Write 0x2=0x4000678E, 0x3=0x40006502, 0x4=0x3CE44000, 0x5=0x40004000, 0x6=0x3E6D3CE4 -> active coefficients stay 0.
  - Then write 0x7=1 and pulse sample_tick -> b0_1=0x4000, a1_1=0x6502, a2_2=0x3CE4, single cfg_update pulse, STATUS[0]=0.
- Write 0x0 with [13:9]=5 and write 0x9 -> PSLVERR=1 on both, CTRL unchanged, STATUS[15:8]=2.
- Assert COMMIT in the same cycle as sample_tick -> no update on that tick; update on the next tick.
- Assert PRESETn low during the ACCESS cycle of a 0x2 write -> register stays 0. The next full transfer completes normally.

Source files
------------

// File: rtl/dfe_apb_slave.sv
// dfe_apb_slave: APB register block for DFE config (enables, CIC factor, notch biquad coefficients).
// Define DFE_APB_SHADOW_EN to stage coefficients in shadow registers and apply them on a sample_tick after COMMIT.
module dfe_apb_slave #(
  parameter int ABP_ADDR_WIDTH = 4,
  parameter int ABP_DATA_WIDTH = 32,
  parameter int DFE_DATA_WIDTH = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [ABP_ADDR_WIDTH-1:0] PADDR,
  input  logic [ABP_DATA_WIDTH-1:0] PWDATA,
  output logic [ABP_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic                      sample_tick,
  output logic [4:0]                blk_en,
  output logic [4:0]                cic_log2_d,
  output logic [DFE_DATA_WIDTH-1:0] b0_1, b1_1, b2_1, a1_1, a2_1,
  output logic [DFE_DATA_WIDTH-1:0] b0_2, b1_2, b2_2, a1_2, a2_2,
  output logic                      cfg_update
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t st, nxt;
  logic access, err, we, coef_we, pending, hi;
  logic [2:0] idx;
  logic [3:0] ci, ci1;
  logic [7:0] err_cnt;
  logic [ABP_DATA_WIDTH-1:0] rd;
  logic [DFE_DATA_WIDTH-1:0] rd_u, rd_l;
  logic [DFE_DATA_WIDTH-1:0] act [10];
  assign idx = PADDR[2:0];
  assign hi = |PADDR[ABP_ADDR_WIDTH-1:3];
  assign ci = {idx - 3'd2, 1'b0};
  assign ci1 = {idx - 3'd2, 1'b1};
  // st == SETUP means the setup phase was seen on the last edge, so PENABLE now marks the access phase
  always_comb begin
    nxt = (PSEL && !PENABLE) ? SETUP : (st == SETUP && PSEL && PENABLE) ? ACCESS : IDLE;
    access = st == SETUP && PSEL && PENABLE;
    err = access && (hi || (PWRITE && idx == 3'd1) || (PWRITE && idx == 3'd0 && PWDATA[13:9] > 5'd4));
    we = access && PWRITE && !err;
    coef_we = we && idx >= 3'd2 && idx <= 3'd6;
  end
  assign PREADY = access;
  assign PSLVERR = err;
  assign rd = (!hi && idx == 3'd0) ? ABP_DATA_WIDTH'({cic_log2_d, 4'b0, blk_en}) :
              (!hi && idx == 3'd1) ? ABP_DATA_WIDTH'({err_cnt, 7'b0, pending}) :
              (!hi && idx >= 3'd2 && idx <= 3'd6) ? {rd_u, rd_l} : '0;
  assign {b0_1, b1_1, b2_1, a1_1, a2_1} = {act[0], act[1], act[2], act[3], act[4]};
  assign {b0_2, b1_2, b2_2, a1_2, a2_2} = {act[5], act[6], act[7], act[8], act[9]};
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) st <= IDLE;
    else st <= nxt;
`ifdef DFE_APB_SHADOW_EN
  logic [DFE_DATA_WIDTH-1:0] shd [10];
  logic commit_w;
  assign commit_w = we && idx == 3'd7 && PWDATA[0];
  assign rd_u = shd[ci];
  assign rd_l = shd[ci1];
  // a COMMIT landing on a tick edge re-arms pending, so it waits for the following tick
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      shd <= '{default: '0};
      pending <= 1'b0;
    end else begin
      if (coef_we) begin
        shd[ci] <= PWDATA[2*DFE_DATA_WIDTH-1:DFE_DATA_WIDTH];
        shd[ci1] <= PWDATA[DFE_DATA_WIDTH-1:0];
      end
      if (commit_w) pending <= 1'b1;
      else if (sample_tick) pending <= 1'b0;
    end
  end
`else
  assign pending = 1'b0;
  assign rd_u = act[ci];
  assign rd_l = act[ci1];
`endif
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PRDATA <= '0;
      blk_en <= '0;
      cic_log2_d <= '0;
      err_cnt <= '0;
      cfg_update <= 1'b0;
      act <= '{default: '0};
    end else begin
      PRDATA <= (PSEL && !PENABLE && !PWRITE) ? rd : '0;
      if (err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      if (we && idx == 3'd0) begin
        blk_en <= PWDATA[4:0];
        cic_log2_d <= PWDATA[13:9];
      end
`ifdef DFE_APB_SHADOW_EN
      cfg_update <= sample_tick && pending;
      if (sample_tick && pending) act <= shd;
`else
      cfg_update <= coef_we;
      if (coef_we) begin
        act[ci] <= PWDATA[2*DFE_DATA_WIDTH-1:DFE_DATA_WIDTH];
        act[ci1] <= PWDATA[DFE_DATA_WIDTH-1:0];
      end
`endif
    end
  end
endmodule

// File: tb/tb_dfe_apb_slave.sv
// tb_dfe_apb_slave: directed plus random APB traffic against a register-map model of dfe_apb_slave.
module tb_dfe_apb_slave;
  logic CLK_tb = 1'b0;
  logic PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0, sample_tick = 1'b0;
  logic [3:0] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR, cfg_update;
  logic [4:0] blk_en, cic_log2_d;
  logic [15:0] b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2;
  logic [169:0] dut_outs;
  assign dut_outs = {blk_en, cic_log2_d, b0_1, b1_1, b2_1, a1_1, a2_1, b0_2, b1_2, b2_2, a1_2, a2_2};

  dfe_apb_slave dut (
    .PCLK(CLK_tb), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .sample_tick(sample_tick), .blk_en(blk_en), .cic_log2_d(cic_log2_d),
    .b0_1(b0_1), .b1_1(b1_1), .b2_1(b2_1), .a1_1(a1_1), .a2_1(a2_1),
    .b0_2(b0_2), .b1_2(b1_2), .b2_2(b2_2), .a1_2(a1_2), .a2_2(a2_2),
    .cfg_update(cfg_update)
  );

  always #5 CLK_tb = ~CLK_tb;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] rd_got;
  logic [4:0] m_blk, m_cic;
  logic [7:0] m_errc;
  bit m_pend;
  logic [15:0] m_sh [10];
  logic [15:0] m_act [10];

  task automatic chk(input string tag, input logic [169:0] got, input logic [169:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_blk = '0; m_cic = '0; m_errc = '0; m_pend = 0;
    for (int i = 0; i < 10; i++) begin m_sh[i] = '0; m_act[i] = '0; end
  endtask

  function automatic bit m_err(input logic [3:0] a, input bit w, input logic [31:0] d);
    return a >= 4'd8 || (w && a == 4'd1) || (w && a == 4'd0 && d[13:9] > 5'd4);
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int k;
    k = (int'(a) - 2) * 2;
    if (a == 4'd0) return {18'b0, m_cic, 4'b0, m_blk};
    if (a == 4'd1) return {16'b0, m_errc, 7'b0, m_pend};
    if (a >= 4'd2 && a <= 4'd6) return {m_sh[k], m_sh[k+1]};
    return 32'h0;
  endfunction

  function automatic logic [169:0] m_outs();
    logic [169:0] r;
    r = {m_blk, m_cic, 160'b0};
    for (int i = 0; i < 10; i++) r[159-16*i -: 16] = m_act[i];
    return r;
  endfunction

  // one clock edge of the register map: optional transfer v, optional tick tk
  task automatic m_edge(input bit v, input logic [3:0] a, input bit w, input logic [31:0] d,
                        input bit tk, output bit upd);
    int k;
    upd = 0;
    k = (int'(a) - 2) * 2;
`ifdef DFE_APB_SHADOW_EN
    if (tk && m_pend) begin m_act = m_sh; upd = 1; m_pend = 0; end
`endif
    if (v) begin
      if (m_err(a, w, d)) begin
        if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
      end else if (w) begin
        if (a == 4'd0) begin m_blk = d[4:0]; m_cic = d[13:9]; end
        else if (a >= 4'd2 && a <= 4'd6) begin
          m_sh[k] = d[31:16]; m_sh[k+1] = d[15:0];
`ifndef DFE_APB_SHADOW_EN
          m_act[k] = d[31:16]; m_act[k+1] = d[15:0]; upd = 1;
`endif
        end
`ifdef DFE_APB_SHADOW_EN
        else if (a == 4'd7 && d[0]) m_pend = 1;
`endif
      end
    end
  endtask

  task automatic xfer(input logic [3:0] a, input bit w, input logic [31:0] d, input bit tk);
    bit e, upd;
    logic [31:0] er;
    PSEL = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = d; sample_tick = 0;
    #1 chk("setup_pready", PREADY, 0);
    @(negedge CLK_tb);
    PENABLE = 1; sample_tick = tk;
    #1;
    e = m_err(a, w, d);
    er = m_read(a);
    rd_got = PRDATA;
    chk("pready", PREADY, 1);
    chk("pslverr", PSLVERR, e);
    if (!w) chk("prdata", PRDATA, er);
    @(negedge CLK_tb);
    PSEL = 0; PENABLE = 0; sample_tick = 0;
    m_edge(1, a, w, d, tk, upd);
    #1;
    chk("cfg_update", cfg_update, upd);
    chk("outs", dut_outs, m_outs());
    chk("prdata_idle", PRDATA, 0);
  endtask

  task automatic tick();
    bit upd;
    sample_tick = 1;
    @(negedge CLK_tb);
    sample_tick = 0;
    m_edge(0, 4'd0, 0, 32'h0, 1, upd);
    #1;
    chk("tick_upd", cfg_update, upd);
    chk("tick_outs", dut_outs, m_outs());
    @(negedge CLK_tb);
    #1 chk("upd_pulse", cfg_update, 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0] a;
    m_reset();
    repeat (2) @(negedge CLK_tb);
    #1;
    chk("rst_outs", dut_outs, 0);
    chk("rst_upd", cfg_update, 0);
    chk("rst_pready", PREADY, 0);
    chk("rst_prdata", PRDATA, 0);
    PRESETn = 1;
    for (int i = 0; i < 8; i++) begin
      xfer(4'(i), 0, 32'h0, 0);
      chk("rst_read", rd_got, 0);
    end
    xfer(4'd0, 1, 32'h0000_081F, 0);
    chk("blk_en", blk_en, 5'h1F);
    chk("cic", cic_log2_d, 5'd4);
    xfer(4'd0, 0, 32'h0, 0);
    chk("ctrl_rd", rd_got, 32'h0000_081F);
    xfer(4'd2, 1, 32'h4000_678E, 0);
    xfer(4'd3, 1, 32'h4000_6502, 0);
    xfer(4'd4, 1, 32'h3CE4_4000, 0);
    xfer(4'd5, 1, 32'h4000_4000, 0);
    xfer(4'd6, 1, 32'h3E6D_3CE4, 0);
    xfer(4'd3, 0, 32'h0, 0);
    chk("coef_rd", rd_got, 32'h4000_6502);
    xfer(4'd7, 1, 32'h1, 0);
    tick();
    chk("b0_1", b0_1, 16'h4000);
    chk("a1_1", a1_1, 16'h6502);
    chk("a2_2", a2_2, 16'h3CE4);
    xfer(4'd1, 0, 32'h0, 0);
    chk("status_pend", rd_got[0], 0);
    xfer(4'd0, 1, 32'h0000_0A00, 0);
    xfer(4'd9, 1, 32'h1234_5678, 0);
    chk("ctrl_kept", {blk_en, cic_log2_d}, {5'h1F, 5'd4});
    xfer(4'd1, 0, 32'h0, 0);
    chk("err_cnt", rd_got[15:8], 8'd2);
    xfer(4'd9, 0, 32'h0, 0);
    chk("bad_rd", rd_got, 0);
    xfer(4'd2, 1, 32'h1234_5678, 0);
    xfer(4'd7, 1, 32'h1, 1);
    tick();
    chk("late_commit", b0_1, 16'h1234);
    PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 4'd0; PWDATA = 32'h0;
    #1 chk("nosetup_pready", PREADY, 0);
    @(negedge CLK_tb);
    PSEL = 0; PENABLE = 0;
    #1 chk("nosetup_outs", dut_outs, m_outs());
    PSEL = 1; PENABLE = 0; PADDR = 4'd2; PWRITE = 1; PWDATA = 32'hDEAD_BEEF;
    @(negedge CLK_tb);
    PENABLE = 1;
    #1 PRESETn = 0;
    @(negedge CLK_tb);
    PSEL = 0; PENABLE = 0;
    #1 PRESETn = 1;
    m_reset();
    chk("midrst_outs", dut_outs, 0);
    xfer(4'd2, 0, 32'h0, 0);
    chk("midrst_rd", rd_got, 0);
    xfer(4'd2, 1, 32'hCAFE_0001, 0);
    xfer(4'd2, 0, 32'h0, 0);
    chk("post_rst_rd", rd_got, 32'hCAFE_0001);
    for (int n = 0; n < 80; n++) begin
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a == 4'd0 && $urandom_range(0, 1) == 1) d[13:9] = 5'($urandom_range(0, 4));
      if (a == 4'd7 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
      xfer(a, $urandom_range(0, 1) == 1, d, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) tick();
    end
    repeat (260) xfer(4'hF, 1, $urandom, 0);
    xfer(4'd1, 0, 32'h0, 0);
    chk("err_sat", rd_got[15:8], 8'd255);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
